// File: rtl/zap_dwb_pkg.sv
// Shared constants and types for the data Wishbone sequencer.
// FSM encodings, grant-owner type and the default bus watchdog limit.
package zap_dwb_pkg;

  localparam logic [31:0] TIMEOUT_CYCLES_DEF = 32'd256;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_P_BUSY = 2'd1;
  localparam state_t ST_T_BUSY = 2'd2;
  localparam state_t ST_DRAIN  = 2'd3;

  typedef enum logic {
    OWN_P = 1'b0,
    OWN_T = 1'b1
  } owner_e;

endpackage

// File: rtl/zap_dwb_watchdog.sv
// Bus-cycle watchdog: counts busy cycles since the last grant and flags
// expiry in the cycle the count reaches LIMIT-1 (built only with ZAP_DWB_TIMEOUT_EN).
module zap_dwb_watchdog
  import zap_dwb_pkg::*;
#(
  parameter logic [31:0] LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expire
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (i_clear) begin
      count_d = '0;
    end else if (i_enable) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_expire = i_enable & (count_q == (LIMIT - 32'd1));

endmodule

// File: rtl/zap_dwb_sequencer.sv
// Data Wishbone master sequencer: arbitrates pipeline and MMU walker, owns the
// bus cycle until ACK/ERR. Optional bus watchdog under ZAP_DWB_TIMEOUT_EN.
module zap_dwb_sequencer
  import zap_dwb_pkg::*;
#(
  parameter logic [31:0] TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_clear_from_writeback,
  input  logic        i_p_cyc,
  input  logic        i_p_stb,
  input  logic        i_p_we,
  input  logic [31:0] i_p_adr,
  input  logic [31:0] i_p_dat,
  input  logic [3:0]  i_p_sel,
  output logic        o_p_stall,
  output logic        o_p_fault,
  output logic [31:0] o_p_dat,
  input  logic        i_t_req,
  input  logic [31:0] i_t_adr,
  output logic        o_t_ack,
  output logic        o_t_err,
  output logic [31:0] o_t_dat,
  output logic        o_wb_cyc,
  output logic        o_wb_stb,
  output logic        o_wb_we,
  output logic [31:0] o_wb_adr,
  output logic [31:0] o_wb_dat,
  output logic [3:0]  o_wb_sel,
  input  logic        i_wb_ack,
  input  logic        i_wb_err,
  input  logic [31:0] i_wb_dat
);

  state_t      state_q, state_d;
  owner_e      last_q, last_d;
  logic        wb_cyc_q, wb_cyc_d;
  logic        wb_we_q, wb_we_d;
  logic [31:0] wb_adr_q, wb_adr_d;
  logic [31:0] wb_dat_q, wb_dat_d;
  logic [3:0]  wb_sel_q, wb_sel_d;
  logic [31:0] p_dat_q, p_dat_d;
  logic        t_ack_q, t_ack_d;
  logic        t_err_q, t_err_d;
  logic [31:0] t_dat_q, t_dat_d;

  logic p_valid, p_ok, t_valid, grant_p, grant_t;
  logic wd_expire, bus_ack, bus_err, bus_term, p_term;

  assign p_valid = i_p_cyc & i_p_stb;
  assign p_ok    = p_valid & ~i_clear_from_writeback;
  // The walker keeps i_t_req high during its response pulse; mask it so the
  // same request is not granted twice.
  assign t_valid = i_t_req & ~t_ack_q & ~t_err_q;
  assign grant_t = (state_q == ST_IDLE) & t_valid & (~p_ok | (last_q == OWN_P));
  assign grant_p = (state_q == ST_IDLE) & p_ok & ~grant_t;

  // Watchdog expiry is a termination that looks like ERR unless ACK also arrives.
  assign bus_term = i_wb_ack | i_wb_err | wd_expire;
  assign bus_ack  = i_wb_ack & ~i_wb_err;
  assign bus_err  = i_wb_err | (wd_expire & ~i_wb_ack);
  assign p_term   = (state_q == ST_P_BUSY) & bus_term;

  assign o_p_stall = p_valid & ~p_term & ~i_clear_from_writeback;
  assign o_p_fault = (state_q == ST_P_BUSY) & bus_err & ~i_clear_from_writeback;

`ifdef ZAP_DWB_TIMEOUT_EN
  zap_dwb_watchdog #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_clear   (grant_p | grant_t),
    .i_enable  (state_q != ST_IDLE),
    .o_expire  (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d  = state_q;
    last_d   = last_q;
    wb_cyc_d = wb_cyc_q;
    wb_we_d  = wb_we_q;
    wb_adr_d = wb_adr_q;
    wb_dat_d = wb_dat_q;
    wb_sel_d = wb_sel_q;
    p_dat_d  = p_dat_q;
    t_ack_d  = 1'b0;
    t_err_d  = 1'b0;
    t_dat_d  = t_dat_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_t) begin
          state_d  = ST_T_BUSY;
          last_d   = OWN_T;
          wb_cyc_d = 1'b1;
          wb_we_d  = 1'b0;
          wb_adr_d = i_t_adr;
          wb_sel_d = 4'hF;
        end else if (grant_p) begin
          state_d  = ST_P_BUSY;
          last_d   = OWN_P;
          wb_cyc_d = 1'b1;
          wb_we_d  = i_p_we;
          wb_adr_d = i_p_adr;
          wb_dat_d = i_p_dat;
          wb_sel_d = i_p_sel;
        end
      end
      ST_P_BUSY: begin
        if (bus_term) begin
          state_d  = ST_IDLE;
          wb_cyc_d = 1'b0;
          if (bus_ack && !wb_we_q && !i_clear_from_writeback) begin
            p_dat_d = i_wb_dat;
          end
        end else if (i_clear_from_writeback) begin
          state_d = ST_DRAIN;
        end
      end
      ST_T_BUSY: begin
        if (bus_term) begin
          state_d  = ST_IDLE;
          wb_cyc_d = 1'b0;
          t_ack_d  = bus_ack;
          t_err_d  = bus_err;
          if (bus_ack) begin
            t_dat_d = i_wb_dat;
          end
        end
      end
      ST_DRAIN: begin
        if (bus_term) begin
          state_d  = ST_IDLE;
          wb_cyc_d = 1'b0;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        wb_cyc_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      last_q   <= OWN_P;
      wb_cyc_q <= 1'b0;
      wb_we_q  <= 1'b0;
      wb_adr_q <= '0;
      wb_dat_q <= '0;
      wb_sel_q <= '0;
      p_dat_q  <= '0;
      t_ack_q  <= 1'b0;
      t_err_q  <= 1'b0;
      t_dat_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      last_q   <= last_d;
      wb_cyc_q <= wb_cyc_d;
      wb_we_q  <= wb_we_d;
      wb_adr_q <= wb_adr_d;
      wb_dat_q <= wb_dat_d;
      wb_sel_q <= wb_sel_d;
      p_dat_q  <= p_dat_d;
      t_ack_q  <= t_ack_d;
      t_err_q  <= t_err_d;
      t_dat_q  <= t_dat_d;
    end
  end

  assign o_wb_cyc = wb_cyc_q;
  assign o_wb_stb = wb_cyc_q;
  assign o_wb_we  = wb_we_q;
  assign o_wb_adr = wb_adr_q;
  assign o_wb_dat = wb_dat_q;
  assign o_wb_sel = wb_sel_q;
  assign o_p_dat  = p_dat_q;
  assign o_t_ack  = t_ack_q;
  assign o_t_err  = t_err_q;
  assign o_t_dat  = t_dat_q;

endmodule

// File: tb/tb_zap_dwb_sequencer.sv
// Directed bench for zap_dwb_sequencer with read-data scoreboards.
// The watchdog section runs only when ZAP_DWB_TIMEOUT_EN is defined.
module tb_zap_dwb_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_clear_from_writeback;
  logic        i_p_cyc, i_p_stb, i_p_we;
  logic [31:0] i_p_adr, i_p_dat;
  logic [3:0]  i_p_sel;
  logic        o_p_stall, o_p_fault;
  logic [31:0] o_p_dat;
  logic        i_t_req;
  logic [31:0] i_t_adr;
  logic        o_t_ack, o_t_err;
  logic [31:0] o_t_dat;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack, i_wb_err;
  logic [31:0] i_wb_dat;

  typedef struct packed {
    logic        ack;
    logic        err;
    logic [31:0] dat;
  } t_exp_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] p_q[$];
  t_exp_t      t_q[$];
  logic [31:0] exp_p_dat;
  logic [31:0] exp_t_dat;

  always #5 clk = ~clk;

  zap_dwb_sequencer #(
    .TIMEOUT_CYCLES (32'd8)
  ) dut (
    .i_clk                  (clk),
    .i_reset_n              (rst_n),
    .i_clear_from_writeback (i_clear_from_writeback),
    .i_p_cyc                (i_p_cyc),
    .i_p_stb                (i_p_stb),
    .i_p_we                 (i_p_we),
    .i_p_adr                (i_p_adr),
    .i_p_dat                (i_p_dat),
    .i_p_sel                (i_p_sel),
    .o_p_stall              (o_p_stall),
    .o_p_fault              (o_p_fault),
    .o_p_dat                (o_p_dat),
    .i_t_req                (i_t_req),
    .i_t_adr                (i_t_adr),
    .o_t_ack                (o_t_ack),
    .o_t_err                (o_t_err),
    .o_t_dat                (o_t_dat),
    .o_wb_cyc               (o_wb_cyc),
    .o_wb_stb               (o_wb_stb),
    .o_wb_we                (o_wb_we),
    .o_wb_adr               (o_wb_adr),
    .o_wb_dat               (o_wb_dat),
    .o_wb_sel               (o_wb_sel),
    .i_wb_ack               (i_wb_ack),
    .i_wb_err               (i_wb_err),
    .i_wb_dat               (i_wb_dat)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic p_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    i_p_cyc = 1'b1;
    i_p_stb = 1'b1;
    i_p_we  = we;
    i_p_adr = adr;
    i_p_dat = dat;
    i_p_sel = sel;
  endtask

  task automatic p_drop();
    i_p_cyc = 1'b0;
    i_p_stb = 1'b0;
  endtask

  task automatic bus_resp(input logic ack, input logic err, input logic [31:0] dat);
    i_wb_ack = ack;
    i_wb_err = err;
    i_wb_dat = dat;
  endtask

  task automatic check_p_dat(input string tag);
    logic [31:0] e;
    e = p_q.pop_front();
    check(tag, o_p_dat, e);
  endtask

  // Waits (bounded) for the walker response pulse, then checks it and
  // releases the walker request as the walker itself would.
  task automatic wait_walker(input string tag);
    t_exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (o_t_ack || o_t_err) break;
      tick();
    end
    check({tag, "_resp_seen"}, {31'd0, o_t_ack | o_t_err}, 32'd1);
    e = t_q.pop_front();
    check({tag, "_t_ack"}, {31'd0, o_t_ack}, {31'd0, e.ack});
    check({tag, "_t_err"}, {31'd0, o_t_err}, {31'd0, e.err});
    check({tag, "_t_dat"}, o_t_dat, e.dat);
    i_t_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    rst_n = 1'b0;
    i_clear_from_writeback = 1'b0;
    i_p_cyc = 1'b0; i_p_stb = 1'b0; i_p_we = 1'b0;
    i_p_adr = '0; i_p_dat = '0; i_p_sel = '0;
    i_t_req = 1'b0; i_t_adr = '0;
    i_wb_ack = 1'b0; i_wb_err = 1'b0; i_wb_dat = '0;
    exp_p_dat = '0;
    exp_t_dat = '0;

    tick();
    tick();
    check("rst_wb_cyc", {31'd0, o_wb_cyc}, 32'd0);
    check("rst_wb_adr", o_wb_adr, 32'd0);
    check("rst_p_stall", {31'd0, o_p_stall}, 32'd0);
    check("rst_p_fault", {31'd0, o_p_fault}, 32'd0);
    check("rst_t_ack", {31'd0, o_t_ack}, 32'd0);
    check("rst_p_dat", o_p_dat, 32'd0);
    rst_n = 1'b1;
    tick();

    // Tie from reset: walker wins, pipeline follows.
    p_req(1'b0, 32'h300, 32'h0, 4'hF);
    i_t_req = 1'b1;
    i_t_adr = 32'h400;
    settle();
    check("tie1_stall", {31'd0, o_p_stall}, 32'd1);
    tick();
    check("tie1_first_adr", o_wb_adr, 32'h400);
    check("tie1_first_we", {31'd0, o_wb_we}, 32'd0);
    check("tie1_first_sel", {28'd0, o_wb_sel}, 32'hF);
    bus_resp(1'b1, 1'b0, 32'h1111_2222);
    exp_t_dat = 32'h1111_2222;
    t_q.push_back('{ack: 1'b1, err: 1'b0, dat: exp_t_dat});
    settle();
    check("tie1_stall_walker_busy", {31'd0, o_p_stall}, 32'd1);
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    wait_walker("tie1");
    tick();
    check("tie1_second_adr", o_wb_adr, 32'h300);
    check("tie1_second_cyc", {31'd0, o_wb_cyc}, 32'd1);
    check("tie1_t_ack_pulse", {31'd0, o_t_ack}, 32'd0);
    bus_resp(1'b1, 1'b0, 32'h3333_4444);
    exp_p_dat = 32'h3333_4444;
    p_q.push_back(exp_p_dat);
    settle();
    check("tie1_p_stall_ack", {31'd0, o_p_stall}, 32'd0);
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    p_drop();
    check_p_dat("tie1_p_dat");
    check("tie1_cyc_drop", {31'd0, o_wb_cyc}, 32'd0);

    // Walker alone, so the next tie goes to the pipeline.
    i_t_req = 1'b1;
    i_t_adr = 32'h500;
    tick();
    check("walk_adr", o_wb_adr, 32'h500);
    bus_resp(1'b1, 1'b0, 32'h5555_0000);
    exp_t_dat = 32'h5555_0000;
    t_q.push_back('{ack: 1'b1, err: 1'b0, dat: exp_t_dat});
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    wait_walker("walk");
    tick();

    p_req(1'b0, 32'h600, 32'h0, 4'hF);
    i_t_req = 1'b1;
    i_t_adr = 32'h700;
    tick();
    check("tie2_first_adr", o_wb_adr, 32'h600);
    bus_resp(1'b1, 1'b0, 32'h6666_6666);
    exp_p_dat = 32'h6666_6666;
    p_q.push_back(exp_p_dat);
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    p_drop();
    check_p_dat("tie2_p_dat");
    tick();
    check("tie2_second_adr", o_wb_adr, 32'h700);
    bus_resp(1'b1, 1'b0, 32'h7777_7777);
    exp_t_dat = 32'h7777_7777;
    t_q.push_back('{ack: 1'b1, err: 1'b0, dat: exp_t_dat});
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    wait_walker("tie2");
    tick();

    // Pipeline load, ACK in the third bus cycle.
    p_req(1'b0, 32'h100, 32'h0, 4'hF);
    settle();
    check("ld_stall_req", {31'd0, o_p_stall}, 32'd1);
    tick();
    check("ld_cyc", {31'd0, o_wb_cyc}, 32'd1);
    check("ld_stb", {31'd0, o_wb_stb}, 32'd1);
    check("ld_adr", o_wb_adr, 32'h100);
    check("ld_stall_busy1", {31'd0, o_p_stall}, 32'd1);
    tick();
    check("ld_stall_busy2", {31'd0, o_p_stall}, 32'd1);
    tick();
    bus_resp(1'b1, 1'b0, 32'hDEAD_BEEF);
    exp_p_dat = 32'hDEAD_BEEF;
    p_q.push_back(exp_p_dat);
    settle();
    check("ld_stall_ack", {31'd0, o_p_stall}, 32'd0);
    check("ld_fault_ack", {31'd0, o_p_fault}, 32'd0);
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    p_drop();
    check_p_dat("ld_p_dat");
    check("ld_cyc_drop", {31'd0, o_wb_cyc}, 32'd0);
    tick();

    // Pipeline store terminated by ERR.
    p_req(1'b1, 32'h200, 32'hCAFE_F00D, 4'b0011);
    tick();
    check("st_we", {31'd0, o_wb_we}, 32'd1);
    check("st_sel", {28'd0, o_wb_sel}, 32'h3);
    check("st_wdat", o_wb_dat, 32'hCAFE_F00D);
    bus_resp(1'b0, 1'b1, 32'h0BAD_0BAD);
    p_q.push_back(exp_p_dat);
    settle();
    check("st_fault_err", {31'd0, o_p_fault}, 32'd1);
    check("st_stall_err", {31'd0, o_p_stall}, 32'd0);
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    p_drop();
    check("st_fault_after", {31'd0, o_p_fault}, 32'd0);
    check("st_cyc_drop", {31'd0, o_wb_cyc}, 32'd0);
    check_p_dat("st_p_dat_kept");
    tick();

    // Flush in IDLE blocks the pipeline grant for that cycle.
    p_req(1'b0, 32'h240, 32'h0, 4'hF);
    i_clear_from_writeback = 1'b1;
    settle();
    check("idle_clr_stall", {31'd0, o_p_stall}, 32'd0);
    tick();
    check("idle_clr_no_grant", {31'd0, o_wb_cyc}, 32'd0);
    i_clear_from_writeback = 1'b0;
    tick();
    check("idle_clr_grant_after", o_wb_adr, 32'h240);
    bus_resp(1'b1, 1'b0, 32'hA5A5_A5A5);
    exp_p_dat = 32'hA5A5_A5A5;
    p_q.push_back(exp_p_dat);
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    p_drop();
    check_p_dat("idle_clr_p_dat");
    tick();

    // Flush during P_BUSY drains the bus and discards the ACK data.
    p_req(1'b0, 32'h800, 32'h0, 4'hF);
    tick();
    check("drn_cyc", {31'd0, o_wb_cyc}, 32'd1);
    i_clear_from_writeback = 1'b1;
    settle();
    check("drn_stall_clr", {31'd0, o_p_stall}, 32'd0);
    tick();
    i_clear_from_writeback = 1'b0;
    p_drop();
    check("drn_cyc_held", {31'd0, o_wb_cyc}, 32'd1);
    tick();
    bus_resp(1'b1, 1'b0, 32'h0000_1234);
    p_q.push_back(exp_p_dat);
    settle();
    check("drn_no_fault", {31'd0, o_p_fault}, 32'd0);
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    check("drn_cyc_drop", {31'd0, o_wb_cyc}, 32'd0);
    check_p_dat("drn_p_dat_kept");
    p_req(1'b0, 32'h840, 32'h0, 4'hF);
    tick();
    check("drn_idle_regrant", o_wb_adr, 32'h840);
    bus_resp(1'b1, 1'b0, 32'h0840_0840);
    exp_p_dat = 32'h0840_0840;
    p_q.push_back(exp_p_dat);
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    p_drop();
    check_p_dat("drn_next_p_dat");
    tick();

    // Walker sees ACK and ERR together: ERR wins, data unchanged.
    i_t_req = 1'b1;
    i_t_adr = 32'h900;
    tick();
    check("ae_cyc", {31'd0, o_wb_cyc}, 32'd1);
    bus_resp(1'b1, 1'b1, 32'h5555_5555);
    t_q.push_back('{ack: 1'b0, err: 1'b1, dat: exp_t_dat});
    tick();
    bus_resp(1'b0, 1'b0, 32'h0);
    wait_walker("ack_err");
    tick();

`ifdef ZAP_DWB_TIMEOUT_EN
    // No termination: watchdog ends the cycle in the 8th busy cycle.
    p_req(1'b0, 32'hA00, 32'h0, 4'hF);
    tick();
    for (int i = 1; i < 8; i++) begin
      check($sformatf("to_busy%0d_cyc", i), {31'd0, o_wb_cyc}, 32'd1);
      check($sformatf("to_busy%0d_fault", i), {31'd0, o_p_fault}, 32'd0);
      tick();
    end
    check("to_fault", {31'd0, o_p_fault}, 32'd1);
    check("to_stall", {31'd0, o_p_stall}, 32'd0);
    tick();
    p_drop();
    check("to_cyc_drop", {31'd0, o_wb_cyc}, 32'd0);
    tick();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/zap_dwb_sequencer.md
# zap_dwb_sequencer

Sequences and arbitrates the single data Wishbone master port between two requesters: the post-ALU memory stage (pipeline loads/stores) and the MMU table walker (read-only). It owns the bus cycle: registers the granted request onto the bus, holds it until ACK/ERR, returns read data, and produces the post-ALU stage's data-stall and data-fault inputs. Sits between the post-ALU stage/walker and the data cache/bus interconnect.

## Interface
- TIMEOUT_CYCLES, 32'd256, bus watchdog limit in cycles (used only with ZAP_DWB_TIMEOUT_EN)
- i_clk  in  1  clock
- i_reset_n  in  1  reset, asynchronous, active-low
- i_clear_from_writeback  in  1  pipeline flush
- i_p_cyc, i_p_stb, i_p_we  in  1 each  pipeline request (valid = cyc & stb)
- i_p_adr, i_p_dat  in  32 each  pipeline address / write data
- i_p_sel  in  4  pipeline byte selects
- o_p_stall  out  1  data stall to post-ALU stage
- o_p_fault  out  1  data memory fault to post-ALU stage
- o_p_dat  out  32  pipeline read data
- i_t_req  in  1  walker read request
- i_t_adr  in  32  walker address
- o_t_ack, o_t_err  out  1 each  walker completion / error
- o_t_dat  out  32  walker read data
- o_wb_cyc, o_wb_stb, o_wb_we  out  1 each  Wishbone master controls
- o_wb_adr, o_wb_dat  out  32 each  Wishbone address / write data
- o_wb_sel  out  4  Wishbone byte selects
- i_wb_ack, i_wb_err  in  1 each  Wishbone termination
- i_wb_dat  in  32  Wishbone read data

## Operation
- States: IDLE, P_BUSY, T_BUSY, DRAIN.
- IDLE: single valid requester granted; both valid → grant the one not granted last (last_grant reset = pipeline, so walker wins first tie). Pipeline not granted in a cycle with i_clear_from_writeback=1. Grant registers adr/dat/sel/we onto o_wb_* with cyc=stb=1; walker grants force we=0, sel=4'hF.
- P_BUSY/T_BUSY: bus outputs held stable until i_wb_ack or i_wb_err, then cyc=stb=0, → IDLE.
- P_BUSY + ACK: o_p_dat <= i_wb_dat (loads; stores leave it unchanged).
- P_BUSY + ERR: o_p_fault=1 that cycle.
- T_BUSY + ACK/ERR: o_t_ack/o_t_err pulse 1 cycle (registered, cycle after termination); o_t_dat <= i_wb_dat on ACK.
- i_clear_from_writeback in P_BUSY → DRAIN (same-cycle ACK/ERR → IDLE, discarded). DRAIN holds bus until ACK/ERR, discards data, no fault, → IDLE. Walker unaffected by clear.
- o_p_stall (combinational) = pipeline valid & !(state==P_BUSY & (i_wb_ack|i_wb_err)) & !i_clear_from_writeback.
- o_p_fault (combinational) = state==P_BUSY & i_wb_err & !i_clear_from_writeback.
- ACK and ERR same cycle: treated as ERR.

## Timing
- Reset (async assert, sync deassert by system): state IDLE, all o_* 0, last_grant = pipeline.
- Pipeline request valid cycle N (bus idle) → o_wb_cyc at N+1 → ACK at N+k → o_p_stall low in N+k; o_p_dat valid from N+k+1. Minimum 2-cycle stall-free turnaround not guaranteed; zero-wait ACK gives k=1.
- Walker: request N → cyc N+1 → ACK N+k → o_t_ack N+k+1. Walker holds i_t_req/i_t_adr until o_t_ack/o_t_err.
- Back-to-back: new grant earliest the cycle after termination (one idle bus cycle).
- Reset mid-cycle: bus dropped immediately; interconnect must tolerate.

## Configuration
- ZAP_DWB_TIMEOUT_EN defined: counter clears on grant, increments each busy/DRAIN cycle; reaching TIMEOUT_CYCLES-1 with no termination acts as ERR (fault to owner, none in DRAIN), cyc/stb drop, → IDLE.
- Undefined: no counter; bus waits indefinitely.

## Structure
- zap_dwb_pkg: state enum, grant-owner enum, TIMEOUT_CYCLES default.
- One sub-module: zap_dwb_watchdog (counter, clear/enable in, expire out), instantiated only under ZAP_DWB_TIMEOUT_EN.

## Test plan
- Pipeline load adr 0x100, ACK after 3 cycles with dat 0xDEADBEEF → cyc 1 cycle later, o_p_stall high until ACK cycle, o_p_dat=0xDEADBEEF next cycle.
- Pipeline store sel 4'b0011 with ERR → o_p_fault=1 in ERR cycle, stall drops, no o_p_dat change.
- Walker and pipeline requesting together from reset → walker first (o_t_ack), then pipeline; repeat tie → pipeline first.
- Clear during P_BUSY, ACK 2 cycles later with 0x1234 → DRAIN, o_p_dat unchanged, no fault, then IDLE.
- ACK and ERR same cycle on walker → o_t_err=1, o_t_ack=0.
- With ZAP_DWB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no ACK → cyc drops after 8 busy cycles, o_p_fault=1.
